// File: rtl/psram_req_seq_if.sv
// Request, configuration and completion bundle around the PSRAM request sequencer.
interface psram_req_seq_if;
    logic        req_vld;
    logic        req_rdy;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic        req_dir;
    logic [14:0] req_len;
    logic [16:0] req_saddr;
    logic [15:0] req_mode;
    logic        abort;
    logic        start;
    logic        done;
    logic [31:0] cfg0;
    logic [31:0] cfg1;
    logic [31:0] cfg2;
    logic [31:0] cfg3;
    logic        busy;
    logic        cmp_vld;
    logic        cmp_err;
    logic [7:0]  cmp_cnt;

    modport master (
        output req_vld, req_cmd, req_addr, req_dir, req_len, req_saddr, req_mode,
        output abort, done,
        input  req_rdy, start, cfg0, cfg1, cfg2, cfg3, busy, cmp_vld, cmp_err, cmp_cnt
    );

    modport slave (
        input  req_vld, req_cmd, req_addr, req_dir, req_len, req_saddr, req_mode,
        input  abort, done,
        output req_rdy, start, cfg0, cfg1, cfg2, cfg3, busy, cmp_vld, cmp_err, cmp_cnt
    );
endinterface

// File: rtl/psram_req_seq.sv
// Queues PSRAM transfer requests and sequences them one at a time into psram_trx,
// converting each into cfg words, a start pulse and a completion/timeout report.
module psram_req_seq #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TMO_CYC = 65535
) (
    input  logic           clk,
    input  logic           rst,
    psram_req_seq_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = 16;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic        dir;
        logic [14:0] len;
        logic [16:0] saddr;
        logic [15:0] mode;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    entry_t             fifo_q [DEPTH];
    entry_t             head, wr_entry;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               rdy_en_q;
    logic               full, empty, push, tmo_hit;
    logic               pop_c, start_c, tmo_clr_c, cmp_set_c, cmp_err_c;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    // No bypass: ready depends only on occupancy, abort and reset release.
    assign bus.req_rdy = rdy_en_q & ~full & ~bus.abort;
    assign push        = bus.req_vld & bus.req_rdy;
    assign wr_entry    = {bus.req_cmd, bus.req_addr, bus.req_dir, bus.req_len,
                          bus.req_saddr, bus.req_mode};
    assign head        = fifo_q[rd_ptr_q];
    assign tmo_hit     = (tmo_q == TMO_W'(TMO_CYC - 1));
    assign bus.start   = start_c;
    assign bus.busy    = (state_q != S_IDLE) | ~empty;
    assign bus.cfg3    = '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!bus.abort && !empty) state_d = S_LOAD;
            S_LOAD:  state_d = bus.abort ? S_IDLE : S_START;
            S_START: state_d = bus.abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (bus.abort)                 state_d = S_IDLE;
                else if (bus.done || tmo_hit)  state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop_c     = 1'b0;
        start_c   = 1'b0;
        tmo_clr_c = 1'b0;
        cmp_set_c = 1'b0;
        cmp_err_c = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                pop_c     = ~bus.abort;
                cmp_set_c = bus.abort;
                cmp_err_c = 1'b1;
            end
            S_START: begin
                start_c   = ~bus.abort;
                tmo_clr_c = 1'b1;
                cmp_set_c = bus.abort;
                cmp_err_c = 1'b1;
            end
            S_WAIT: begin
                // done takes priority over a coinciding timeout
                cmp_set_c = bus.abort | bus.done | tmo_hit;
                cmp_err_c = bus.abort | ~bus.done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst)                   tmo_q <= '0;
        else if (tmo_clr_c)        tmo_q <= '0;
        else if (state_q == S_WAIT) tmo_q <= tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        rdy_en_q <= ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cmp_vld <= 1'b0;
            bus.cmp_err <= 1'b0;
            bus.cmp_cnt <= '0;
            bus.cfg0    <= '0;
            bus.cfg1    <= '0;
            bus.cfg2    <= '0;
        end else begin
            bus.cmp_vld <= cmp_set_c;
            bus.cmp_err <= cmp_set_c & cmp_err_c;
            if (cmp_set_c) bus.cmp_cnt <= bus.cmp_cnt + 8'd1;
            if (pop_c) begin
                bus.cfg0 <= {head.mode[15:5], head.dir, head.mode[4:0], head.len};
                bus.cfg1 <= {head.cmd, head.addr};
                bus.cfg2 <= {head.saddr, head.len};
            end
        end
    end
endmodule

// File: tb/tb_psram_req_seq.sv
// Self-checking bench for psram_req_seq: directed vectors, corner sequences and a
// randomized run scored against a transaction-level model.
module tb_psram_req_seq;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;
    localparam int unsigned NRAND = 3000;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic        dir;
        logic [14:0] len;
        logic [16:0] saddr;
        logic [15:0] mode;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    typedef struct {
        req_t        req;
        logic [31:0] cfg0;
        logic [31:0] cfg1;
        logic [31:0] cfg2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;
    int          last_start = -1;

    psram_req_seq_if bus();

    psram_req_seq #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Every pair of start pulses must be at least 4 cycles apart.
    always @(negedge clk) begin
        if (!rst && bus.start === 1'b1) begin
            if (last_start >= 0)
                chk("start_gap_ge4", 32'(int'(cyc) - last_start >= 4), 32'd1);
            last_start = int'(cyc);
        end
    end

    function automatic logic [31:0] model_cfg0(input req_t r);
        logic [1:0] cmd_w, addr_w, data_w;
        logic       cmd_only, sl_io;
        logic [3:0] wait_c, sck;
        {cmd_w, cmd_only, addr_w, wait_c, data_w, sl_io, sck} = r.mode;
        return {cmd_w, cmd_only, addr_w, wait_c, data_w, r.dir, sl_io, sck, r.len};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input req_t r);
        bus.req_cmd   = r.cmd;
        bus.req_addr  = r.addr;
        bus.req_dir   = r.dir;
        bus.req_len   = r.len;
        bus.req_saddr = r.saddr;
        bus.req_mode  = r.mode;
    endtask

    task automatic push_one(input req_t r, output int acc);
        acc = -1;
        drive_req(r);
        bus.req_vld = 1'b1;
        for (int i = 0; i < 60 && acc < 0; i++) begin
            #1;
            if (bus.req_rdy) acc = int'(cyc);
            tick();
        end
        bus.req_vld = 1'b0;
        if (acc < 0) chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_start(output int s, input int limit);
        s = -1;
        for (int i = 0; i < limit && s < 0; i++) begin
            if (bus.start) s = int'(cyc);
            else tick();
        end
        if (s < 0) chk("start_timeout", 32'd1, 32'd0);
    endtask

    // Called in a START cycle: done in the first WAIT cycle, success one cycle later.
    task automatic complete_ok(input string name);
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk({name, "_cmp_vld"}, 32'(bus.cmp_vld), 32'd1);
        chk({name, "_cmp_err"}, 32'(bus.cmp_err), 32'd0);
        exp_cnt++;
        tick();
    endtask

    task automatic run_random();
        req_t        q[$];
        req_t        r, h;
        logic [95:0] rnd;
        int          done_cyc, cmp_cyc, cnt_cyc, c, d;
        logic        exp_err;
        done_cyc = -1; cmp_cyc = -1; cnt_cyc = -1; exp_err = 1'b0;
        r = '0;
        for (int i = 0; i < int'(NRAND) + 400; i++) begin
            c = int'(cyc);
            if (bus.start) begin
                chk("rnd_start_has_entry", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    h = q.pop_front();
                    chk("rnd_cfg0", bus.cfg0, model_cfg0(h));
                    chk("rnd_cfg1", bus.cfg1, {h.cmd, h.addr});
                    chk("rnd_cfg2", bus.cfg2, {h.saddr, h.len});
                    chk("rnd_cfg3", bus.cfg3, 32'd0);
                    d = int'($urandom_range(1, 10));
                    done_cyc = c + d;
                    // WAIT spans TMO cycles; a done inside it wins, otherwise timeout.
                    if (d <= int'(TMO)) begin cmp_cyc = c + d + 1;       exp_err = 1'b0; end
                    else                begin cmp_cyc = c + int'(TMO) + 1; exp_err = 1'b1; end
                end
            end
            if (bus.cmp_vld) begin
                chk("rnd_cmp_time", 32'(c), 32'(cmp_cyc));
                chk("rnd_cmp_err", 32'(bus.cmp_err), 32'(exp_err));
                exp_cnt++;
                cnt_cyc = c + 1;
            end else if (c == cmp_cyc) begin
                chk("rnd_cmp_missing", 32'(bus.cmp_vld), 32'd1);
            end
            if (c == cnt_cyc) chk("rnd_cmp_cnt", 32'(bus.cmp_cnt), 32'(8'(exp_cnt)));
            bus.done = (c == done_cyc);
            if (i < int'(NRAND) && $urandom_range(0, 2) == 0) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                r   = rnd[REQ_W-1:0];
                drive_req(r);
                bus.req_vld = 1'b1;
            end else begin
                bus.req_vld = 1'b0;
            end
            #1;
            if (bus.req_vld && bus.req_rdy) q.push_back(r);
            tick();
        end
        bus.done    = 1'b0;
        bus.req_vld = 1'b0;
        chk("rnd_queue_drained", 32'(q.size()), 32'd0);
        chk("rnd_busy_end", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        req_t rq;
        int   acc, s, n, seen;

        vecs[0] = '{req: '{cmd: 8'hEB, addr: 24'h123456, dir: 1'b1, len: 15'd16,
                           saddr: 17'h00100, mode: 16'hA5C3},
                    cfg0: 32'hA5D18010, cfg1: 32'hEB123456, cfg2: 32'h00800010};
        vecs[1] = '{req: '{cmd: 8'h03, addr: 24'h000000, dir: 1'b0, len: 15'd0,
                           saddr: 17'h1FFFF, mode: 16'h0000},
                    cfg0: 32'h00000000, cfg1: 32'h03000000, cfg2: 32'hFFFF8000};
        vecs[2] = '{req: '{cmd: 8'hFF, addr: 24'hFFFFFF, dir: 1'b1, len: 15'h7FFF,
                           saddr: 17'h00000, mode: 16'hFFFF},
                    cfg0: 32'hFFFFFFFF, cfg1: 32'hFFFFFFFF, cfg2: 32'h00007FFF};
        vecs[3] = '{req: '{cmd: 8'h38, addr: 24'hABCDEF, dir: 1'b0, len: 15'h1234,
                           saddr: 17'h0ACE1, mode: 16'h8001},
                    cfg0: 32'h80009234, cfg1: 32'h38ABCDEF, cfg2: 32'h56709234};

        bus.req_vld = 1'b0; bus.abort = 1'b0; bus.done = 1'b0;
        drive_req('0);

        // Reset state
        tick(); tick();
        chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_start",   32'(bus.start),   32'd0);
        chk("rst_cmp_vld", 32'(bus.cmp_vld), 32'd0);
        chk("rst_cmp_err", 32'(bus.cmp_err), 32'd0);
        chk("rst_cmp_cnt", 32'(bus.cmp_cnt), 32'd0);
        chk("rst_cfg0", bus.cfg0, 32'd0);
        chk("rst_cfg1", bus.cfg1, 32'd0);
        chk("rst_cfg2", bus.cfg2, 32'd0);
        chk("rst_cfg3", bus.cfg3, 32'd0);
        rst = 1'b0;
        tick();
        chk("release_req_rdy", 32'(bus.req_rdy), 32'd1);

        // Table-driven single requests
        for (int i = 0; i < 4; i++) begin
            push_one(vecs[i].req, acc);
            wait_start(s, 12);
            chk("vec_start_latency", 32'(s - acc), 32'd3);
            chk("vec_cfg0", bus.cfg0, vecs[i].cfg0);
            chk("vec_cfg1", bus.cfg1, vecs[i].cfg1);
            chk("vec_cfg2", bus.cfg2, vecs[i].cfg2);
            chk("vec_cfg3", bus.cfg3, 32'd0);
            complete_ok("vec");
            chk("vec_cmp_cnt", 32'(bus.cmp_cnt), 32'(8'(exp_cnt)));
        end

        // Fill: back-to-back pushes with no done; one entry moves into flight
        rq = vecs[0].req;
        n  = 0;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rq.cmd = 8'(8'h10 + n);
            drive_req(rq);
            #1;
            if (!bus.req_rdy) break;
            n++;
            tick();
        end
        chk("fill_accepted", 32'(n), 32'(DEPTH + 1));
        chk("fill_rdy_low", 32'(bus.req_rdy), 32'd0);
        chk("fill_busy", 32'(bus.busy), 32'd1);
        bus.req_vld = 1'b0;
        chk("fill_head_cfg1", bus.cfg1, {8'h10, rq.addr});
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("fill_first_cmp", 32'(bus.cmp_vld), 32'd1);
        exp_cnt++;
        for (int j = 1; j <= int'(DEPTH); j++) begin
            wait_start(s, 20);
            chk("fill_order_cfg1", bus.cfg1, {8'(8'h10 + j), rq.addr});
            complete_ok("fill");
        end

        // Timeout with a later stray done
        push_one(vecs[1].req, acc);
        wait_start(s, 12);
        seen = 0;
        for (int k = 1; k <= int'(TMO); k++) begin
            tick();
            if (bus.cmp_vld) seen++;
        end
        chk("tmo_early_cmp", 32'(seen), 32'd0);
        tick();
        chk("tmo_cmp_vld", 32'(bus.cmp_vld), 32'd1);
        chk("tmo_cmp_err", 32'(bus.cmp_err), 32'd1);
        exp_cnt++;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.cmp_vld || bus.start) seen++;
            tick();
        end
        chk("stray_done_ignored", 32'(seen), 32'd0);
        chk("stray_done_cnt", 32'(bus.cmp_cnt), 32'(8'(exp_cnt)));

        // done coinciding with the timeout cycle
        push_one(vecs[2].req, acc);
        wait_start(s, 12);
        for (int k = 1; k <= int'(TMO); k++) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("tie_cmp_vld", 32'(bus.cmp_vld), 32'd1);
        chk("tie_cmp_err", 32'(bus.cmp_err), 32'd0);
        exp_cnt++;
        tick();

        // Abort in WAIT with two entries queued
        rq = vecs[3].req;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rq.cmd = 8'(8'h20 + i);
            drive_req(rq);
            tick();
        end
        bus.req_vld = 1'b0;
        wait_start(s, 12);
        tick(); tick();
        bus.abort = 1'b1;
        bus.req_vld = 1'b1;
        #1;
        chk("abort_rdy_low", 32'(bus.req_rdy), 32'd0);
        tick();
        bus.abort = 1'b0;
        bus.req_vld = 1'b0;
        chk("abort_cmp_vld", 32'(bus.cmp_vld), 32'd1);
        chk("abort_cmp_err", 32'(bus.cmp_err), 32'd1);
        exp_cnt++;
        tick();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.start || bus.cmp_vld) seen++;
            tick();
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        // Abort coinciding with START suppresses the pulse
        push_one(vecs[0].req, acc);
        wait_start(s, 12);
        bus.abort = 1'b1;
        #1;
        chk("abort_start_masked", 32'(bus.start), 32'd0);
        tick();
        bus.abort = 1'b0;
        chk("abort_start_cmp_err", 32'(bus.cmp_err & bus.cmp_vld), 32'd1);
        exp_cnt++;
        tick();
        chk("abort_start_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of WAIT
        push_one(vecs[1].req, acc);
        wait_start(s, 12);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_cmp_vld", 32'(bus.cmp_vld), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rdy", 32'(bus.req_rdy), 32'd0);
        chk("midrst_cfg1", bus.cfg1, 32'd0);
        chk("midrst_cmp_cnt", 32'(bus.cmp_cnt), 32'd0);
        exp_cnt = 0;
        rst = 1'b0;
        tick();
        chk("midrst_release_rdy", 32'(bus.req_rdy), 32'd1);
        chk("midrst_no_cmp", 32'(bus.cmp_vld), 32'd0);

        // 256 completions wrap the counter
        for (int k = 0; k < 256; k++) begin
            push_one(vecs[k % 4].req, acc);
            wait_start(s, 12);
            complete_ok("wrap");
        end
        chk("wrap_cmp_cnt_zero", 32'(bus.cmp_cnt), 32'd0);

        run_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
